logic_unit_arbiter: RTL and testbench

- Shares one registered bitwise logic unit (AND/OR/XOR/NAND) among N requesters.
- Arbitration is round-robin. Each grant runs one operation through a fixed 3-phase sequence: grant, execute, respond.
- Sits between multiple client blocks and the shared gate-level logic datapath. Sequences the datapath so only one operand pair is evaluated at a time.

---
 rtl/logic_unit_arbiter_if.sv | 26 ++
 rtl/logic_unit_arbiter.sv | 161 ++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_if.sv
// Request/operand bundle and grant/result bundle between the clients and logic_unit_arbiter.
// The arbiter connects through the slave modport; the client side uses master.
interface logic_unit_arbiter_if #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
);
   logic [N-1:0]   req;
   logic [2*N-1:0] op;
   logic [N*W-1:0] A;
   logic [N*W-1:0] B;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [W-1:0]   Y;
   logic           busy;
   logic [15:0]    op_count;

   modport master (
      output req, op, A, B,
      input  gnt, done, Y, busy, op_count
   );

   modport slave (
      input  req, op, A, B,
      output gnt, done, Y, busy, op_count
   );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/NAND unit among N requesters.
// Each granted operation walks IDLE -> GRANT -> EXEC; every output comes straight from a flop.
module logic_unit_arbiter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   logic_unit_arbiter_if.slave io_bus
);
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned SumW = IdxW + 1;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StExec
   } state_e;

   state_e          r_state;
   logic [IdxW-1:0] r_last;
   logic [W-1:0]    r_opa;
   logic [W-1:0]    r_opb;
   logic [1:0]      r_op;
   logic [N-1:0]    r_gnt;
   logic [N-1:0]    r_done;
   logic [W-1:0]    r_y;
   logic            r_busy;
   logic [15:0]     r_op_count;

   state_e          w_state_nxt;
   logic [IdxW-1:0] w_last_nxt;
   logic [W-1:0]    w_opa_nxt;
   logic [W-1:0]    w_opb_nxt;
   logic [1:0]      w_op_nxt;
   logic [N-1:0]    w_gnt_nxt;
   logic [N-1:0]    w_done_nxt;
   logic [W-1:0]    w_y_nxt;
   logic            w_busy_nxt;
   logic [15:0]     w_cnt_nxt;

   logic [W-1:0]    w_a_arr  [N];
   logic [W-1:0]    w_b_arr  [N];
   logic [1:0]      w_op_arr [N];

   logic [2*N-1:0]  w_req2;
   logic [SumW-1:0] w_base;
   logic [N-1:0]    w_rot;
   logic [IdxW-1:0] w_off;
   logic [SumW-1:0] w_sum;
   logic [IdxW-1:0] w_win;
   logic            w_found;
   logic [W-1:0]    w_result;

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign w_a_arr[g]  = io_bus.A[g*W +: W];
      assign w_b_arr[g]  = io_bus.B[g*W +: W];
      assign w_op_arr[g] = io_bus.op[2*g +: 2];
   end

   // Rotate req so bit 0 is requester last+1, take the lowest set bit, then undo the rotation.
   always_comb begin
      w_req2  = {io_bus.req, io_bus.req};
      w_base  = {1'b0, r_last} + SumW'(1);
      w_rot   = w_req2[w_base +: N];
      w_found = 1'b0;
      w_off   = '0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!w_found && w_rot[IdxW'(j)]) begin
            w_found = 1'b1;
            w_off   = IdxW'(j);
         end
      end
      w_sum = w_base + SumW'(w_off);
      w_win = (w_sum >= SumW'(N)) ? IdxW'(w_sum - SumW'(N)) : IdxW'(w_sum);
   end

   always_comb begin
      unique case (r_op)
         2'b00:   w_result = r_opa & r_opb;
         2'b01:   w_result = r_opa | r_opb;
         2'b10:   w_result = r_opa ^ r_opb;
         default: w_result = ~(r_opa & r_opb);
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_opa_nxt   = r_opa;
      w_opb_nxt   = r_opb;
      w_op_nxt    = r_op;
      w_gnt_nxt   = '0;
      w_done_nxt  = '0;
      w_y_nxt     = r_y;
      w_busy_nxt  = 1'b0;
      w_cnt_nxt   = r_op_count;

      unique case (r_state)
         StIdle: begin
            if (w_found) begin
               w_opa_nxt   = w_a_arr[w_win];
               w_opb_nxt   = w_b_arr[w_win];
               w_op_nxt    = w_op_arr[w_win];
               w_last_nxt  = w_win;
               w_gnt_nxt   = N'(1) << w_win;
               w_busy_nxt  = 1'b1;
               w_state_nxt = StGrant;
            end
         end
         StGrant: begin
            w_y_nxt     = w_result;
            w_done_nxt  = N'(1) << r_last;
            w_busy_nxt  = 1'b1;
            w_state_nxt = StExec;
         end
         StExec: begin
            if (r_op_count != 16'hFFFF) begin
               w_cnt_nxt = r_op_count + 16'd1;
            end
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Pointer resets to N-1 so requester 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_last     <= IdxW'(N - 1);
         r_opa      <= '0;
         r_opb      <= '0;
         r_op       <= '0;
         r_gnt      <= '0;
         r_done     <= '0;
         r_y        <= '0;
         r_busy     <= 1'b0;
         r_op_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_last     <= w_last_nxt;
         r_opa      <= w_opa_nxt;
         r_opb      <= w_opb_nxt;
         r_op       <= w_op_nxt;
         r_gnt      <= w_gnt_nxt;
         r_done     <= w_done_nxt;
         r_y        <= w_y_nxt;
         r_busy     <= w_busy_nxt;
         r_op_count <= w_cnt_nxt;
      end
   end

   assign io_bus.gnt      = r_gnt;
   assign io_bus.done     = r_done;
   assign io_bus.Y        = r_y;
   assign io_bus.busy     = r_busy;
   assign io_bus.op_count = r_op_count;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-timestamp reference model.
module tb_logic_unit_arbiter;
   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic_unit_arbiter_if #(.N(N), .W(W)) bus ();

   logic_unit_arbiter #(.N(N), .W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: each accepted operation is stamped with the cycle it was taken.
   int             cyc = 0;
   int             m_acc;
   int             m_free;
   int unsigned    m_last;
   int unsigned    m_win;
   logic [W-1:0]   m_res;
   logic [W-1:0]   m_y;
   logic [15:0]    m_cnt;

   logic [N-1:0]   gq [$];
   logic [W-1:0]   opc_tab [4] = '{8'h0A, 8'hAF, 8'hA5, 8'hF5};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] ref_f(input logic [1:0] opc, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (opc)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic model_reset();
      m_acc  = -100;
      m_free = -100;
      m_last = N - 1;
      m_win  = 0;
      m_res  = '0;
      m_y    = '0;
      m_cnt  = '0;
   endtask

   task automatic model_step();
      bit found;
      int unsigned k;
      cyc++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (cyc == m_acc + 1) m_y = m_res;
      if (cyc == m_acc + 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (cyc >= m_free && bus.req != '0) begin
         found = 1'b0;
         for (int unsigned i = 1; i <= N; i++) begin
            k = (m_last + i) % N;
            if (!found && bus.req[k]) begin
               found = 1'b1;
               m_win = k;
            end
         end
         m_last = m_win;
         m_res  = ref_f(bus.op[2*m_win +: 2], bus.A[m_win*W +: W], bus.B[m_win*W +: W]);
         m_acc  = cyc;
         m_free = cyc + 3;
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] oh;
      logic [N-1:0] e_gnt;
      logic [N-1:0] e_done;
      oh         = '0;
      oh[m_win]  = 1'b1;
      e_gnt      = (cyc == m_acc) ? oh : '0;
      e_done     = (cyc == m_acc + 1) ? oh : '0;
      check("gnt", bus.gnt, e_gnt);
      check("done", bus.done, e_done);
      check("Y", bus.Y, m_y);
      check("busy", bus.busy, (cyc == m_acc || cyc == m_acc + 1));
      check("op_count", bus.op_count, m_cnt);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic set_client(input int unsigned k, input logic [1:0] opc, input logic [W-1:0] a,
                             input logic [W-1:0] b);
      bus.op[2*k +: 2] = opc;
      bus.A[k*W +: W]  = a;
      bus.B[k*W +: W]  = b;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n   = 1'b0;
      bus.req = '0;
      bus.op  = '0;
      bus.A   = '0;
      bus.B   = '0;
      model_reset();

      // Reset then idle
      cycle();
      cycle();
      rst_n = 1'b1;
      repeat (10) cycle();

      // Single AND on requester 0
      set_client(0, 2'b00, 8'hF0, 8'h3C);
      bus.req = 4'b0001;
      cycle();
      check("and_gnt", bus.gnt, 4'b0001);
      bus.req = '0;
      cycle();
      check("and_done", bus.done, 4'b0001);
      check("and_y", bus.Y, 8'h30);
      cycle();
      cycle();
      check("and_cnt", bus.op_count, 16'd1);

      // Round-robin with all requesters held high
      do_reset();
      for (int k = 0; k < N; k++) set_client(k, 2'b01, W'($urandom), W'($urandom));
      bus.req = '1;
      gq.delete();
      repeat (12) begin
         cycle();
         if (bus.gnt != '0) gq.push_back(bus.gnt);
      end
      bus.req = '0;
      repeat (3) cycle();
      check("rr_count", gq.size(), 4);
      for (int i = 0; i < 4 && i < gq.size(); i++) check("rr_order", gq[i], 32'(1) << i);
      check("rr_ops", bus.op_count, 16'd4);

      // After requester 0 is served, 1001 must go to requester 3
      do_reset();
      set_client(0, 2'b10, 8'h55, 8'hFF);
      set_client(3, 2'b00, 8'h81, 8'hC3);
      bus.req = 4'b0001;
      cycle();
      bus.req = '0;
      cycle();
      cycle();
      bus.req = 4'b1001;
      cycle();
      check("rr_after0", bus.gnt, 4'b1000);
      bus.req = '0;
      cycle();
      check("rr_after0_y", bus.Y, 8'h81);
      cycle();

      // All opcodes on requester 2
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_client(2, 2'(i), 8'hAA, 8'h0F);
         bus.req = 4'b0100;
         cycle();
         bus.req = '0;
         bus.A   = '1;
         cycle();
         check("opc_done", bus.done, 4'b0100);
         check("opc_y", bus.Y, opc_tab[i]);
         cycle();
      end

      // Reset during GRANT discards the operation
      do_reset();
      set_client(0, 2'b01, 8'h12, 8'h34);
      bus.req = 4'b0001;
      cycle();
      check("mid_gnt", bus.gnt, 4'b0001);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_rst_gnt", bus.gnt, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_y", bus.Y, 0);
      bus.req = '0;
      cycle();
      cycle();
      rst_n = 1'b1;
      repeat (4) begin
         cycle();
         check("mid_no_done", bus.done, 0);
      end
      check("mid_cnt", bus.op_count, 0);
      bus.req = 4'b1001;
      cycle();
      check("mid_first", bus.gnt, 4'b0001);
      bus.req = '0;
      cycle();
      cycle();

      // Saturation of op_count
      do_reset();
      force dut.r_op_count = 16'hFFFE;
      m_cnt = 16'hFFFE;
      cycle();
      release dut.r_op_count;
      #1;
      check("sat_pre", bus.op_count, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         set_client(1, 2'($urandom), W'($urandom), W'($urandom));
         bus.req = 4'b0010;
         cycle();
         bus.req = '0;
         cycle();
         cycle();
      end
      cycle();
      check("sat_cnt", bus.op_count, 16'hFFFF);

      // Randomized traffic with occasional asynchronous resets
      do_reset();
      repeat (600) begin
         bus.req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         bus.op  = (2*N)'($urandom);
         bus.A   = (N*W)'($urandom);
         bus.B   = (N*W)'($urandom);
         rst_n   = ($urandom_range(0, 59) != 0);
         cycle();
      end
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
